// File: rtl/jt51_csr_ring_if.sv
// jt51_csr_ring_if -- bus bundle between the register-write decoder / host
// and the jt51_csr_ring control-register store.
//
// Signals:
//   cen      ring clock enable (one slot per enabled cycle)
//   din      new field values for the current slot
//   wmask    per-bit select: 1 = take din, 0 = keep stored bit
//   drop     stored value of the current slot
//   slot     index of the current slot
//   busy     high while the reset initialisation sweep runs
//   rd_req   readback request strobe
//   rd_slot  slot to read back
//   rd_ack   one-clk strobe, rd_data / rd_err valid
//   rd_data  captured slot value
//   rd_err   requested slot out of range
//
// Modports: master = decoder/host side, slave = the ring itself.
interface jt51_csr_ring_if #(
  parameter int WIDTH = 31,
  parameter int SW    = 5
);
  logic             cen;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] drop;
  logic [SW-1:0]    slot;
  logic             busy;
  logic             rd_req;
  logic [SW-1:0]    rd_slot;
  logic             rd_ack;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;

  modport master (
    output cen, din, wmask, rd_req, rd_slot,
    input  drop, slot, busy, rd_ack, rd_data, rd_err
  );

  modport slave (
    input  cen, din, wmask, rd_req, rd_slot,
    output drop, slot, busy, rd_ack, rd_data, rd_err
  );
endinterface

// File: rtl/jt51_csr_ring.sv
// jt51_csr_ring -- parametrised rotating control-register store for the
// JT51 operator/envelope pipeline.
//
// Behaves like a STAGES-deep shift register with a per-bit feedback mux,
// but keeps the slots in a memory array with a registered read so the
// storage lands in block RAM. After reset an INIT sweep writes RSTVAL into
// every slot (busy=1) before normal merging starts.
//
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   jt51_csr_ring_if.slave: cen/din/wmask in, drop/slot/busy out,
//         plus the host readback port rd_req/rd_slot -> rd_ack/rd_data/rd_err
//
// Build option:
//   JT51_CSR_RDBK_EN  when defined, the readback FSM and rd_data register are
//                     built; otherwise rd_ack/rd_err/rd_data are tied to 0.
module jt51_csr_ring #(
  parameter int               WIDTH  = 31,
  parameter int               STAGES = 32,
  parameter int               SW     = 5,
  parameter logic [WIDTH-1:0] RSTVAL = {WIDTH{1'b0}}
) (
  input logic            clk,
  input logic            rst,
  jt51_csr_ring_if.slave bus
);

  typedef enum logic {ST_INIT, ST_RUN} ring_state_t;

  localparam logic [SW-1:0] LAST_SLOT = SW'(STAGES - 1);

  ring_state_t      state_reg, state_next;
  logic [SW-1:0]    slot_reg;
  logic [SW-1:0]    slot_inc;
  logic [WIDTH-1:0] drop_reg;
  logic [WIDTH-1:0] wr_val;

  logic [WIDTH-1:0] mem [STAGES];

  // Slot counter wraps at STAGES, which need not be a power of two.
  assign slot_inc = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;

  // Value going back into the current slot. drop_reg always holds the
  // current slot's stored value, so it is the "keep" side of the merge.
  assign wr_val = (state_reg == ST_INIT) ? RSTVAL
                : (bus.din & bus.wmask) | (drop_reg & ~bus.wmask);

  // Ring FSM: INIT sweeps every slot once, then RUN forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: if (bus.cen && slot_reg == LAST_SLOT) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
    endcase
  end

  // Slot pointer and registered memory read. The read address is one slot
  // ahead, so after the advance drop_reg is the new slot's contents. Since
  // STAGES >= 2 the read and write addresses never collide. During INIT the
  // memory may still hold garbage, so drop is pinned to RSTVAL instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg <= '0;
      drop_reg <= RSTVAL;
    end else if (bus.cen) begin
      slot_reg <= slot_inc;
      drop_reg <= (state_reg == ST_INIT) ? RSTVAL : mem[slot_inc];
    end
  end

  // Memory write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (bus.cen) mem[slot_reg] <= wr_val;
  end

  assign bus.drop = drop_reg;
  assign bus.slot = slot_reg;
  assign bus.busy = (state_reg == ST_INIT);

`ifdef JT51_CSR_RDBK_EN
  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;

  localparam logic [SW:0] STAGES_EXT = (SW+1)'(STAGES);

  rd_state_t        rd_state_reg, rd_state_next;
  logic [SW-1:0]    rd_slot_reg, rd_slot_next;
  logic             rd_ack_reg, rd_ack_next;
  logic             rd_err_reg, rd_err_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= RD_IDLE;
      rd_slot_reg  <= '0;
      rd_ack_reg   <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_slot_reg  <= rd_slot_next;
      rd_ack_reg   <= rd_ack_next;
      rd_err_reg   <= rd_err_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  // Requests are only looked at in IDLE; anything arriving while a read is
  // pending is dropped. The capture uses wr_val so a same-cycle write to the
  // requested slot is visible in rd_data.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_slot_next  = rd_slot_reg;
    rd_ack_next   = 1'b0;
    rd_err_next   = rd_err_reg;
    rd_data_next  = rd_data_reg;
    case (rd_state_reg)
      RD_IDLE: begin
        if (bus.rd_req) begin
          if ({1'b0, bus.rd_slot} >= STAGES_EXT) begin
            rd_ack_next  = 1'b1;
            rd_err_next  = 1'b1;
            rd_data_next = '0;
          end else begin
            rd_slot_next  = bus.rd_slot;
            rd_state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (bus.cen && state_reg == ST_RUN && slot_reg == rd_slot_reg) begin
          rd_ack_next   = 1'b1;
          rd_err_next   = 1'b0;
          rd_data_next  = wr_val;
          rd_state_next = RD_IDLE;
        end
      end
    endcase
  end

  assign bus.rd_ack  = rd_ack_reg;
  assign bus.rd_err  = rd_err_reg;
  assign bus.rd_data = rd_data_reg;
`else
  // Readback port present but inert.
  logic unused_rd;
  assign unused_rd   = ^{bus.rd_req, bus.rd_slot};
  assign bus.rd_ack  = 1'b0;
  assign bus.rd_err  = 1'b0;
  assign bus.rd_data = '0;
`endif

endmodule

// File: tb/tb_jt51_csr_ring.sv
// tb_jt51_csr_ring -- self-checking bench for jt51_csr_ring.
//
// dut_a: WIDTH=31, STAGES=32, SW=6 (wide enough to request slot 40), RSTVAL=0.
// dut_b: WIDTH=11, STAGES=32, SW=5, RSTVAL=11'h7FF, cen toggling 1-of-2.
// dut_a is compared every cycle against an array-of-slots model; readback
// expectations depend on whether JT51_CSR_RDBK_EN is defined.
module tb_jt51_csr_ring;

  localparam int W   = 31;
  localparam int N   = 32;
  localparam int SWA = 6;
  localparam int WB  = 11;
  localparam int SWB = 5;
  localparam logic [WB-1:0] RSTB = 11'h7FF;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  jt51_csr_ring_if #(.WIDTH(W),  .SW(SWA)) a_if ();
  jt51_csr_ring_if #(.WIDTH(WB), .SW(SWB)) b_if ();

  jt51_csr_ring #(.WIDTH(W), .STAGES(N), .SW(SWA), .RSTVAL({W{1'b0}})) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if)
  );

  jt51_csr_ring #(.WIDTH(WB), .STAGES(N), .SW(SWB), .RSTVAL(RSTB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for dut_a: slot contents as a plain array plus the
  // rules for the sweep and the readback handshake.
  logic [W-1:0] m [N];
  int           m_slot;
  bit           m_run;
  int           m_cnt;
  bit           m_wait;
  int           m_rslot;
  bit           e_ack;
  bit           e_err;
  logic [W-1:0] e_data;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '0;
    m_slot = 0; m_run = 0; m_cnt = 0; m_wait = 0; m_rslot = 0;
    e_ack = 0; e_err = 0; e_data = '0;
  endtask

  // One clock of dut_a: drive inputs, take the edge, update model, compare.
  task automatic step(input bit c, input logic [W-1:0] d, input logic [W-1:0] w,
                      input bit rq, input logic [SWA-1:0] rs);
    bit           was_wait;
    logic [W-1:0] nv;
    a_if.cen = c; a_if.din = d; a_if.wmask = w; a_if.rd_req = rq; a_if.rd_slot = rs;
    @(posedge clk); #1;
    was_wait = m_wait;
    e_ack    = 0;
    if (c) begin
      if (!m_run) begin
        m_cnt++;
        if (m_cnt == N) m_run = 1;
      end else begin
        nv = (d & w) | (m[m_slot] & ~w);
        if (was_wait && m_slot == m_rslot) begin
          e_ack = 1; e_err = 0; e_data = nv; m_wait = 0;
        end
        m[m_slot] = nv;
      end
      m_slot = (m_slot + 1) % N;
    end
    if (!was_wait && rq) begin
      if (int'(rs) >= N) begin
        e_ack = 1; e_err = 1; e_data = '0;
      end else begin
        m_wait = 1; m_rslot = int'(rs);
      end
    end
    check("slot", 64'(a_if.slot), 64'(m_slot));
    check("busy", 64'(a_if.busy), 64'(!m_run));
    check("drop", 64'(a_if.drop), 64'(m[m_slot]));
`ifdef JT51_CSR_RDBK_EN
    check("rd_ack", 64'(a_if.rd_ack), 64'(e_ack));
    if (e_ack) begin
      check("rd_err", 64'(a_if.rd_err), 64'(e_err));
      check("rd_data", 64'(a_if.rd_data), 64'(e_data));
    end
`else
    check("rd_ack_off", 64'(a_if.rd_ack), 64'd0);
    check("rd_err_off", 64'(a_if.rd_err), 64'd0);
    check("rd_data_off", 64'(a_if.rd_data), 64'd0);
`endif
    a_if.rd_req = 1'b0;
  endtask

  task automatic reset_a();
    a_if.cen = 0; a_if.din = '0; a_if.wmask = '0; a_if.rd_req = 0; a_if.rd_slot = '0;
    rst_a = 1'b1;
    #1;
    model_reset();
    check("rst_slot", 64'(a_if.slot), 64'd0);
    check("rst_drop", 64'(a_if.drop), 64'd0);
    check("rst_busy", 64'(a_if.busy), 64'd1);
    check("rst_rd_ack", 64'(a_if.rd_ack), 64'd0);
    check("rst_rd_data", 64'(a_if.rd_data), 64'd0);
    check("rst_rd_err", 64'(a_if.rd_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    $display("txn reset dut_a");
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    a_if.cen = 0; a_if.din = '0; a_if.wmask = '0; a_if.rd_req = 0; a_if.rd_slot = '0;
    b_if.cen = 0; b_if.din = '0; b_if.wmask = '0; b_if.rd_req = 0; b_if.rd_slot = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // dut_b: RSTVAL=7FF, cen every other clock -> busy for 64 clocks.
    check("b_rst_busy", 64'(b_if.busy), 64'd1);
    check("b_rst_drop", 64'(b_if.drop), 64'(RSTB));
    rst_b = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      b_if.cen   = (i % 2) == 1;
      b_if.din   = WB'($urandom);
      b_if.wmask = WB'($urandom);
      @(posedge clk); #1;
      if (!b_if.busy) begin
        n = i + 1;
        break;
      end
    end
    check("b_busy_clks", 64'(n), 64'd64);
    check("b_slot_after_init", 64'(b_if.slot), 64'd0);
    for (int i = 0; i < N; i++) begin
      b_if.cen = 1; b_if.din = WB'($urandom); b_if.wmask = '0;
      @(posedge clk); #1;
      check("b_drop_rstval", 64'(b_if.drop), 64'(RSTB));
    end
    b_if.cen = 0;
    $display("txn dut_b init sweep busy_clks=%0d", n);

    // dut_a: reset, sweep (din/wmask ignored), then an all-zero lap.
    reset_a();
    for (int i = 0; i < N; i++) step(1, rnd(), rnd(), 0, '0);
    check("a_busy_done", 64'(a_if.busy), 64'd0);
    check("a_slot_wrap", 64'(a_if.slot), 64'd0);
    for (int i = 0; i < N; i++) step(1, rnd(), '0, 0, '0);

    // Partial write at slot 5, then a second merge into the upper half.
    for (int i = 0; i < N && m_slot != 5; i++) step(1, rnd(), '0, 0, '0);
    step(1, 31'h12345678, 31'h0000FFFF, 0, '0);
    $display("txn write slot=5 din=12345678 wmask=0000ffff");
    repeat (N - 1) step(1, rnd(), '0, 0, '0);
    check("w1_drop", 64'(a_if.drop), 64'h00005678);
    step(1, 31'h7FFF0000, 31'h7FFF0000, 0, '0);
    $display("txn write slot=5 din=7fff0000 wmask=7fff0000");
    repeat (N - 1) step(1, rnd(), '0, 0, '0);
    check("w2_drop", 64'(a_if.drop), 64'h7FFF5678);

    // cen low: everything frozen.
    repeat (10) step(0, rnd(), rnd(), 0, '0);
    check("frz_slot", 64'(a_if.slot), 64'd5);
    check("frz_drop", 64'(a_if.drop), 64'h7FFF5678);

    // Readback of slot 5 requested while slot=6; a second request while
    // waiting must not produce an extra ack.
    step(1, rnd(), '0, 0, '0);
    step(1, rnd(), '0, 1, 6'd5);
    $display("txn rd_req slot=5");
    k = 0;
    for (int i = 1; i <= 80; i++) begin
      step(1, rnd(), '0, i == 3, 6'd20);
      if (a_if.rd_ack) begin
        k = i;
        break;
      end
    end
`ifdef JT51_CSR_RDBK_EN
    check("rb_latency", 64'(k), 64'd31);
    check("rb_data", 64'(a_if.rd_data), 64'h7FFF5678);
    check("rb_err", 64'(a_if.rd_err), 64'd0);
`else
    check("rb_no_ack", 64'(k), 64'd0);
`endif
    repeat (40) step(1, rnd(), '0, 0, '0);

    // Out-of-range slot.
    step(0, rnd(), '0, 1, 6'd40);
    $display("txn rd_req slot=40");
`ifdef JT51_CSR_RDBK_EN
    check("oor_ack", 64'(a_if.rd_ack), 64'd1);
    check("oor_err", 64'(a_if.rd_err), 64'd1);
    check("oor_data", 64'(a_if.rd_data), 64'd0);
`endif
    step(0, rnd(), '0, 0, '0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, rnd(), rnd() & rnd(),
           $urandom_range(0, 19) == 0, SWA'($urandom_range(0, 47)));
    end
    $display("txn random traffic done");

    // Reset during a pending read and mid-ring writes.
    step(1, rnd(), rnd(), 1, SWA'((m_slot + 20) % N));
    repeat (5) step(1, rnd(), rnd(), 0, '0);
    reset_a();
    for (int i = 0; i < N; i++) step(1, rnd(), rnd(), 0, '0);
    check("rr_busy_done", 64'(a_if.busy), 64'd0);
    for (int i = 0; i < N; i++) begin
      step(1, rnd(), '0, 0, '0);
      check("rr_drop_rstval", 64'(a_if.drop), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
